// File: rtl/calc_pkg.sv
// Shared definitions for the sequential multiplier: default widths, FSM encoding
// and the width helper for the step counter.
package calc_pkg;

    localparam int A_W_DEF    = 16;
    localparam int B_W_DEF    = 9;
    localparam int P_W_DEF    = 16;
    localparam int PROD_W_DEF = A_W_DEF + B_W_DEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIN  = 2'b10
    } state_e;

    // Bits needed to hold a count that starts at n and runs down to 0.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_mul_unit_if.sv
// START/DONE request bus of the sequential multiplier: operands in, product out.
interface seq_mul_unit_if #(
    parameter int A_W = calc_pkg::A_W_DEF,
    parameter int B_W = calc_pkg::B_W_DEF,
    parameter int P_W = calc_pkg::P_W_DEF
);
    logic           start_i;
    logic [A_W-1:0] a_i;
    logic [B_W-1:0] b_i;
    logic           busy_o;
    logic           done_o;
    logic [P_W-1:0] p_o;
    logic           ovf_o;

    modport slave (
        input  start_i, a_i, b_i,
        output busy_o, done_o, p_o, ovf_o
    );

    modport master (
        output start_i, a_i, b_i,
        input  busy_o, done_o, p_o, ovf_o
    );
endinterface

// File: rtl/seq_mul_cnt.sv
// Loadable down-counter; last_o flags the final step (value == 1).
module seq_mul_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] val_i,
    output logic         last_o
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == ONE);

endmodule

// File: rtl/seq_mul_unit.sv
// Shift-add multiplier, one multiplier bit per clock, fixed latency of B_W steps.
// Accumulator is full width; truncation to P_W happens only at the output register.
module seq_mul_unit
    import calc_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int B_W = B_W_DEF,
    parameter int P_W = P_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    seq_mul_unit_if.slave  bus
);
    localparam int PROD_W = A_W + B_W;
    localparam int CNT_W  = cnt_width(B_W);

    state_e              state_q, state_d;
    logic                accept, step, last;
    logic [PROD_W-1:0]   mcand_q, acc_q, acc_d;
    logic [B_W-1:0]      mplr_q;
    logic [P_W-1:0]      p_q;
    logic                ovf_q, ovf_d;

    seq_mul_cnt #(.W(CNT_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .en_i   (step),
        .val_i  (CNT_W'(B_W)),
        .last_o (last)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign acc_d = mplr_q[0] ? (acc_q + mcand_q) : acc_q;

    // Overflow only exists when the output is narrower than the full product.
    generate
        if (P_W < PROD_W) begin : g_ovf
            assign ovf_d = |acc_d[PROD_W-1:P_W];
        end else begin : g_no_ovf
            assign ovf_d = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mcand_q <= '0;
            mplr_q  <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                mcand_q <= PROD_W'(bus.a_i);
                mplr_q  <= bus.b_i;
                acc_q   <= '0;
            end else if (step) begin
                acc_q   <= acc_d;
                mcand_q <= mcand_q << 1;
                mplr_q  <= mplr_q >> 1;
                if (last) begin
                    p_q   <= acc_d[P_W-1:0];
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign bus.busy_o = (state_q == ST_RUN) || (state_q == ST_FIN);
    assign bus.done_o = (state_q == ST_FIN);
    assign bus.p_o    = p_q;
    assign bus.ovf_o  = ovf_q;

endmodule

// File: tb/tb_seq_mul_unit.sv
// Directed and random checks of seq_mul_unit: result, overflow, latency, handshake, reset.
module tb_seq_mul_unit;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    seq_mul_unit_if bus ();

    seq_mul_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse START for one cycle; returns at the first negedge after the accept edge.
    task automatic issue(input logic [15:0] a, input logic [8:0] b);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.a_i     = a;
        bus.b_i     = b;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.a_i     = 16'($urandom);
        bus.b_i     = 9'($urandom);
    endtask

    // Counts negedges since the accept edge until DONE is seen (bounded).
    task automatic wait_done(input int lat0, output int lat, output int busy_cnt);
        lat      = lat0;
        busy_cnt = 0;
        while (1) begin
            if (bus.busy_o) busy_cnt++;
            if (bus.done_o || lat >= 40) break;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_op(input string tag, input logic [15:0] a, input logic [8:0] b);
        logic [24:0] prod;
        int lat, bc;
        prod = {9'd0, a} * {16'd0, b};
        issue(a, b);
        wait_done(1, lat, bc);
        chk({tag, ".done"}, 32'(bus.done_o), 32'd1);
        chk({tag, ".lat"}, 32'(lat), 32'd10);
        chk({tag, ".busy"}, 32'(bc), 32'd10);
        chk({tag, ".p"}, 32'(bus.p_o), 32'(prod[15:0]));
        chk({tag, ".ovf"}, 32'(bus.ovf_o), 32'(|prod[24:16]));
        @(negedge clk);
        chk({tag, ".done_end"}, 32'(bus.done_o), 32'd0);
        chk({tag, ".idle"}, 32'(bus.busy_o), 32'd0);
    endtask

    initial begin
        int lat, bc, ndone;
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        repeat (3) @(negedge clk);
        chk("rst.busy", 32'(bus.busy_o), 32'd0);
        chk("rst.done", 32'(bus.done_o), 32'd0);
        chk("rst.p", 32'(bus.p_o), 32'd0);
        chk("rst.ovf", 32'(bus.ovf_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        check_op("d5x4", 16'd5, 9'd4);
        chk("d5x4.p20", 32'(bus.p_o), 32'd20);
        check_op("d5040x8", 16'd5040, 9'd8);
        chk("d5040x8.p", 32'(bus.p_o), 32'd40320);
        check_op("d40320x9", 16'd40320, 9'd9);
        chk("d40320x9.p", 32'(bus.p_o), 32'd35200);
        chk("d40320x9.ovf", 32'(bus.ovf_o), 32'd1);
        check_op("dmax", 16'd65535, 9'd511);
        chk("dmax.p", 32'(bus.p_o), 32'd65025);
        chk("dmax.ovf", 32'(bus.ovf_o), 32'd1);
        check_op("da0", 16'd0, 9'd511);
        chk("da0.p", 32'(bus.p_o), 32'd0);
        check_op("db0", 16'd1234, 9'd0);
        chk("db0.p", 32'(bus.p_o), 32'd0);
        chk("db0.ovf", 32'(bus.ovf_o), 32'd0);

        // START pulses during RUN and during FIN must be ignored.
        issue(16'd6, 9'd7);
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.a_i     = 16'd100;
        bus.b_i     = 9'd100;
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_done(3, lat, bc);
        chk("ign.done", 32'(bus.done_o), 32'd1);
        chk("ign.lat", 32'(lat), 32'd10);
        chk("ign.p", 32'(bus.p_o), 32'd42);
        bus.start_i = 1'b1;
        bus.a_i     = 16'd200;
        bus.b_i     = 9'd3;
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("ign.fin_busy", 32'(bus.busy_o), 32'd0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done_o) ndone++;
        end
        chk("ign.ndone", 32'(ndone), 32'd0);
        chk("ign.p_keep", 32'(bus.p_o), 32'd42);

        // START held high: second accept happens in the cycle after DONE.
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.a_i     = 16'd3;
        bus.b_i     = 9'd5;
        @(negedge clk);
        wait_done(1, lat, bc);
        chk("hold.lat", 32'(lat), 32'd10);
        chk("hold.p", 32'(bus.p_o), 32'd15);
        bus.a_i = 16'd4;
        bus.b_i = 9'd9;
        @(negedge clk);
        chk("hold.gap_busy", 32'(bus.busy_o), 32'd0);
        chk("hold.gap_done", 32'(bus.done_o), 32'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        chk("hold.reaccept", 32'(bus.busy_o), 32'd1);
        wait_done(1, lat, bc);
        chk("hold2.lat", 32'(lat), 32'd10);
        chk("hold2.p", 32'(bus.p_o), 32'd36);

        // Reset in the middle of an operation aborts it.
        @(negedge clk);
        issue(16'd300, 9'd200);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort.busy", 32'(bus.busy_o), 32'd0);
        chk("abort.done", 32'(bus.done_o), 32'd0);
        chk("abort.p", 32'(bus.p_o), 32'd0);
        chk("abort.ovf", 32'(bus.ovf_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done_o) ndone++;
        end
        chk("abort.ndone", 32'(ndone), 32'd0);
        check_op("post3x7", 16'd3, 9'd7);
        chk("post3x7.p", 32'(bus.p_o), 32'd21);

        for (int i = 0; i < 1000; i++) begin
            check_op("rnd", 16'($urandom), 9'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
